// File: rtl/ad7606_pkg.sv
// Shared types and constants for the AD7606 parallel-interface emulator.
package ad7606_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RST   = 2'd1,
    CONV  = 2'd2,
    READY = 2'd3
  } state_e;

  localparam int NUM_CH          = 8;
  localparam int PTR_W           = $clog2(NUM_CH);
  localparam int DEF_CONV_CYCLES = 200;
  localparam int CNT_W           = 16;

endpackage : ad7606_pkg

// File: rtl/ad7606_edge_det.sv
// Registered rise/fall detector: compares the input with its value one cycle earlier.
module ad7606_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = d_i;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= RST_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = d_i & ~prev_q;
  assign fall_o = ~d_i & prev_q;

endmodule : ad7606_edge_det

// File: rtl/ad7606_emu.sv
// AD7606 emulator: conversion timing, sample latch and parallel readout.
// Optional protocol checker enabled by defining AD7606_EMU_PROTO_CHECK_EN.
module ad7606_emu
  import ad7606_pkg::*;
#(
  parameter int CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int DATA_W      = 16
) (
  input  logic                     sys_clk_i,
  input  logic                     rst_n_i,
  input  logic                     reset_i,
  input  logic                     convsta_i,
  input  logic                     convstb_i,
  input  logic                     cs_i,
  input  logic                     rd_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  output logic                     busy_o,
  output logic                     frstdata_o,
  output logic [DATA_W-1:0]        ad_data_o
`ifdef AD7606_EMU_PROTO_CHECK_EN
  ,
  output logic                     proto_err_o
`endif
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]    sample_q [NUM_CH];
  logic [DATA_W-1:0]    sample_d [NUM_CH];
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 first_q, first_d;

  logic conv_in;
  logic cst;
  logic unused_conv_fall;
  logic rd_rise, rd_fall;
  logic reset_rise, reset_fall;

  assign conv_in = convsta_i & convstb_i;

  ad7606_edge_det #(.RST_VAL(1'b1)) u_conv_edge (
    .clk    (sys_clk_i),
    .rst_n  (rst_n_i),
    .d_i    (conv_in),
    .rise_o (cst),
    .fall_o (unused_conv_fall)
  );

  ad7606_edge_det #(.RST_VAL(1'b1)) u_rd_edge (
    .clk    (sys_clk_i),
    .rst_n  (rst_n_i),
    .d_i    (rd_i),
    .rise_o (rd_rise),
    .fall_o (rd_fall)
  );

  ad7606_edge_det #(.RST_VAL(1'b0)) u_reset_edge (
    .clk    (sys_clk_i),
    .rst_n  (rst_n_i),
    .d_i    (reset_i),
    .rise_o (reset_rise),
    .fall_o (reset_fall)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    sample_d = sample_q;
    data_d   = data_q;
    busy_d   = busy_q;
    first_d  = first_q;

    if (reset_i) begin
      state_d = RST;
      busy_d  = 1'b0;
      if (reset_rise) begin
        ptr_d   = '0;
        data_d  = '0;
        first_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        RST: begin
          // Entered only with reset_i high, so the first low cycle is always a fall.
          if (reset_fall) state_d = IDLE;
        end
        IDLE, READY: begin
          if (cst) begin
            state_d = CONV;
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(CONV_CYCLES - 1);
            ptr_d   = '0;
            data_d  = '0;
            first_d = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
              sample_d[i] = ch_data_i[i*DATA_W +: DATA_W];
            end
          end else if (state_q == READY && !cs_i) begin
            if (rd_fall) begin
              data_d  = sample_q[ptr_q];
              first_d = (ptr_q == '0);
            end
            if (rd_rise) ptr_d = ptr_q + 1'b1;
          end
        end
        CONV: begin
          if (cnt_q == '0) begin
            state_d = READY;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      first_q <= 1'b0;
      // NOTE: the sample bank is reset because readout right after reset must be defined.
      for (int i = 0; i < NUM_CH; i++) begin
        sample_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      first_q  <= first_d;
      sample_q <= sample_d;
    end
  end

  assign busy_o     = busy_q;
  assign ad_data_o  = (!cs_i && state_q == READY) ? data_q : '0;
  assign frstdata_o = !cs_i && (state_q == READY) && first_q;

`ifdef AD7606_EMU_PROTO_CHECK_EN
  logic [3:0] rdcnt_q, rdcnt_d;
  logic       perr_q, perr_d;
  logic       rd_sel_fall;

  assign rd_sel_fall = rd_fall & ~cs_i;

  always_comb begin
    rdcnt_d = rdcnt_q;
    perr_d  = 1'b0;
    if (cst) begin
      rdcnt_d = '0;
    end else if (rd_sel_fall && rdcnt_q != 4'd9) begin
      rdcnt_d = rdcnt_q + 4'd1;
    end
    if (cst && state_q == CONV) perr_d = 1'b1;
    if (rd_sel_fall && state_q != READY) perr_d = 1'b1;
    // Only the ninth word is flagged; later overruns keep the counter saturated.
    if (!cst && rd_sel_fall && rdcnt_q == 4'd8) perr_d = 1'b1;
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdcnt_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      rdcnt_q <= rdcnt_d;
      perr_q  <= perr_d;
    end
  end

  assign proto_err_o = perr_q;
`endif

endmodule : ad7606_emu

// File: tb/tb_ad7606_emu.sv
// Self-checking bench for ad7606_emu: directed scenarios plus random traffic
// against a cycle-level behavioural model.
module tb_ad7606_emu;

  localparam int CONV = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         reset_i;
  logic         convsta, convstb;
  logic         cs, rd;
  logic [127:0] ch_data;
  logic         busy_o, frstdata_o;
  logic [15:0]  ad_data_o;
`ifdef AD7606_EMU_PROTO_CHECK_EN
  logic         proto_err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int perr_count = 0;

  ad7606_emu #(.CONV_CYCLES(CONV), .DATA_W(16)) dut (
    .sys_clk_i  (clk),
    .rst_n_i    (rst_n),
    .reset_i    (reset_i),
    .convsta_i  (convsta),
    .convstb_i  (convstb),
    .cs_i       (cs),
    .rd_i       (rd),
    .ch_data_i  (ch_data),
    .busy_o     (busy_o),
    .frstdata_o (frstdata_o),
    .ad_data_o  (ad_data_o)
`ifdef AD7606_EMU_PROTO_CHECK_EN
    ,
    .proto_err_o(proto_err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: mode flags plus a conversion end time in cycles.
  int          cyc = 0;
  bit          m_rst = 0, m_conv = 0, m_ready = 0, m_first = 0, m_perr = 0;
  int          m_conv_end = 0;
  int          m_ptr = 0, m_reads = 0;
  logic [15:0] m_word = '0;
  logic [15:0] m_samp [8];
  bit          prev_conv = 1, prev_rd = 1;

  task automatic model_step();
    bit c, cst_e, rdf, rdr, was_conv, was_ready;
    cyc++;
    if (!rst_n) begin
      m_rst = 0; m_conv = 0; m_ready = 0; m_first = 0; m_perr = 0;
      m_ptr = 0; m_reads = 0; m_word = '0;
      prev_conv = 1; prev_rd = 1;
      for (int i = 0; i < 8; i++) m_samp[i] = '0;
      return;
    end
    c     = convsta & convstb;
    cst_e = c & !prev_conv;
    rdf   = !rd & prev_rd;
    rdr   = rd & !prev_rd;
    prev_conv = c;
    prev_rd   = rd;
    was_conv  = m_conv;
    was_ready = m_ready;

    m_perr = (cst_e && was_conv) || (rdf && !cs && !was_ready) ||
             (rdf && !cs && !cst_e && m_reads == 8);
    if (cst_e) m_reads = 0;
    else if (rdf && !cs && m_reads < 9) m_reads++;

    if (reset_i) begin
      m_rst = 1; m_conv = 0; m_ready = 0; m_word = '0; m_first = 0; m_ptr = 0;
    end else if (m_rst) begin
      m_rst = 0;
    end else if (m_conv) begin
      if (cyc >= m_conv_end) begin
        m_conv  = 0;
        m_ready = 1;
      end
    end else if (cst_e) begin
      for (int i = 0; i < 8; i++) m_samp[i] = ch_data[i*16 +: 16];
      m_conv = 1; m_ready = 0; m_conv_end = cyc + CONV;
      m_ptr = 0; m_word = '0; m_first = 0;
    end else if (m_ready && !cs) begin
      if (rdf) begin
        m_word  = m_samp[m_ptr];
        m_first = (m_ptr == 0);
      end
      if (rdr) m_ptr = (m_ptr + 1) % 8;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #2;
    check("busy", 64'(busy_o), 64'(m_conv));
    check("ad_data", 64'(ad_data_o), 64'((!cs && m_ready) ? m_word : 16'h0));
    check("frstdata", 64'(frstdata_o), 64'(!cs && m_ready && m_first));
`ifdef AD7606_EMU_PROTO_CHECK_EN
    check("proto_err", 64'(proto_err_o), 64'(m_perr));
    if (proto_err_o) perr_count++;
`endif
  end

  task automatic set_data(input logic [15:0] base);
    for (int i = 0; i < 8; i++) ch_data[i*16 +: 16] = base + 16'(i);
  endtask

  // Start a conversion (called at a negedge) and pin busy_o for nine cycles.
  task automatic cst_busy(input string tag, input int cst2_at, input int rst_at);
    bit exp;
    convsta = 1; convstb = 1;
    @(negedge clk);
    convsta = 0; convstb = 0;
    for (int j = 1; j <= 9; j++) begin
      exp = (j <= 8);
      if (rst_at != 0 && j > rst_at) exp = 0;
      check($sformatf("%s_busy%0d", tag, j), 64'(busy_o), 64'(exp));
      if (j == cst2_at) begin
        convsta = 1; convstb = 1; set_data(16'h2200);
      end
      if (cst2_at != 0 && j == cst2_at + 1) begin
        convsta = 0; convstb = 0;
      end
      if (j == rst_at) reset_i = 1;
      if (j < 9) @(negedge clk);
    end
  endtask

  task automatic read_word(output logic [15:0] d, output logic f);
    rd = 0;
    @(negedge clk);
    d = ad_data_o;
    f = frstdata_o;
    rd = 1;
    @(negedge clk);
  endtask

  logic [15:0] d;
  logic        f;
  int          perr_before;
  int          r;

  initial begin
    rst_n = 0; reset_i = 0; convsta = 0; convstb = 0; cs = 1; rd = 1; ch_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_data", 64'(ad_data_o), 64'(0));
    check("rst_frst", 64'(frstdata_o), 64'(0));
    rst_n = 1;
    @(negedge clk);

    // Controller reset pulse then a conversion.
    reset_i = 1;
    repeat (2) @(negedge clk);
    reset_i = 0;
    @(negedge clk);
    set_data(16'h0001);
    cst_busy("seq", 0, 0);

    // Full readout of words 1..8.
    cs = 0;
    #1 check("pre_read_data", 64'(ad_data_o), 64'(0));
    for (int i = 0; i < 8; i++) begin
      read_word(d, f);
      check($sformatf("read%0d_data", i + 1), 64'(d), 64'(i + 1));
      check($sformatf("read%0d_frst", i + 1), 64'(f), 64'(i == 0));
    end

    // Ninth read wraps to V1.
    perr_before = perr_count;
    read_word(d, f);
    check("wrap_data", 64'(d), 64'(16'h0001));
    check("wrap_frst", 64'(f), 64'(1));
`ifdef AD7606_EMU_PROTO_CHECK_EN
    check("wrap_proto_pulses", 64'(perr_count - perr_before), 64'(1));
`endif
    cs = 1;
    #1;
    check("cs_high_data", 64'(ad_data_o), 64'(0));
    check("cs_high_frst", 64'(frstdata_o), 64'(0));
    @(negedge clk);

    // Second cst during conversion is ignored.
    set_data(16'h1100);
    cst_busy("ign", 3, 0);
    cs = 0;
    read_word(d, f);
    check("ign_data", 64'(d), 64'(16'h1100));
    check("ign_frst", 64'(f), 64'(1));

    // Controller reset during conversion discards it.
    set_data(16'h5500);
    cst_busy("abort", 0, 2);
    reset_i = 0;
    @(negedge clk);
    read_word(d, f);
    check("abort_data", 64'(d), 64'(0));
    check("abort_frst", 64'(f), 64'(0));

    // Asynchronous reset mid-readout.
    set_data(16'h3300);
    cst_busy("mid", 0, 0);
    for (int i = 0; i < 5; i++) read_word(d, f);
    check("mid_data_before", 64'(ad_data_o), 64'(16'h3304));
    #2 rst_n = 0;
    #1;
    check("async_busy", 64'(busy_o), 64'(0));
    check("async_data", 64'(ad_data_o), 64'(0));
    check("async_frst", 64'(frstdata_o), 64'(0));
    @(negedge clk);
    rst_n = 1;
    set_data(16'h4400);
    @(negedge clk);
    cst_busy("post", 0, 0);
    read_word(d, f);
    check("post_data", 64'(d), 64'(16'h4400));
    check("post_frst", 64'(f), 64'(1));

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 4) begin
        convsta = 1; convstb = 1;
      end else if (r < 7) begin
        convsta = 1; convstb = 0;
      end else if (r < 10) begin
        convsta = 0; convstb = 1;
      end else begin
        convsta = 0; convstb = 0;
      end
      rd      = 1'($urandom_range(0, 1));
      cs      = ($urandom_range(0, 7) == 0);
      reset_i = ($urandom_range(0, 299) == 0);
      ch_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    reset_i = 0; convsta = 0; convstb = 0; rd = 1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ad7606_emu

// File: doc/ad7606_emu.md
AD7606_EMU -- requirements
Module: ad7606_emu

Interface
REQ-001 Parameter CONV_CYCLES, default 200, sets the busy_o high time in sys_clk_i cycles; legal range is 2..65535.
REQ-002 Parameter DATA_W, default 16, sets the width of each channel word.
REQ-003 sys_clk_i  in  1  is the single clock for the block.
REQ-004 rst_n_i  in  1  is the reset, asynchronous and active-low.
REQ-005 reset_i  in  1  is the ADC reset from the controller, active-high.
REQ-006 convsta_i, convstb_i  in  1 each  are the conversion-start inputs; conversion starts on their rising edge.
REQ-007 busy_o  out  1  is high while a conversion is in progress.
REQ-008 frstdata_o  out  1  is high while ad_data_o carries channel V1.
REQ-009 cs_i, rd_i  in  1 each  are the parallel-read chip select and read strobe, both active-low.
REQ-010 ad_data_o  out  DATA_W  is the parallel read data.
REQ-011 ch_data_i  in  8*DATA_W  holds the analog sample values; V1 is in the LSBs.

Function
REQ-012 All inputs SHALL be in the sys_clk_i domain, with no synchronisers; edges SHALL be detected against a one-cycle-delayed copy of each input.
REQ-013 The state machine SHALL have the states IDLE, RST, CONV and READY.
REQ-014 Any state SHALL go to RST while reset_i is 1; RST SHALL go to IDLE on the first cycle with reset_i = 0.
REQ-015 Conversion start ("cst") SHALL be convsta_i & convstb_i = 1 when it was 0 in the previous cycle.
REQ-016 In IDLE or READY, cst SHALL latch ch_data_i into eight sample registers, clear the channel pointer to 0, and enter CONV.
REQ-017 busy_o SHALL go to 1 on the cycle after cst and stay at 1 for exactly CONV_CYCLES cycles; CONV SHALL then go to READY with busy_o = 0.
REQ-018 cst during CONV SHALL be ignored: no relatch and no timer restart.
REQ-019 In READY with cs_i = 0, a falling edge of rd_i SHALL register ad_data_o = sample[ptr] one cycle later.
REQ-020 In READY with cs_i = 0, a rising edge of rd_i SHALL increment ptr; ptr SHALL wrap from 7 to 0.
REQ-021 ad_data_o SHALL be 0 whenever cs_i = 1 or the state is not READY.
REQ-022 frstdata_o SHALL be 1 exactly when cs_i = 0, the state is READY, and ad_data_o holds sample[0].
REQ-023 rd_i edges in IDLE, RST or CONV SHALL neither move ptr nor change ad_data_o.
REQ-024 A cst arriving in READY partway through a readout SHALL abandon the remaining words.
REQ-025 If reset_i rises during CONV, busy_o SHALL be 0 on the next cycle and the conversion SHALL be discarded.

Reset
REQ-026 While rst_n_i = 0: state = IDLE, busy_o = 0, frstdata_o = 0, ad_data_o = 0, ptr = 0, sample registers = 0, edge-detect registers = 1 for convst/rd and 0 for reset_i.
REQ-027 After rst_n_i deasserts, behaviour SHALL be identical to a controller reset_i pulse having completed.

Configuration
REQ-028 With AD7606_EMU_PROTO_CHECK_EN defined, the block SHALL add an output proto_err_o (1 bit, reset 0).
REQ-029 proto_err_o SHALL pulse for one cycle on each of:
  - cst during CONV;
  - an rd_i falling edge with cs_i = 0 outside READY;
  - a 9th rd_i falling edge since the last cst.
REQ-030 Without AD7606_EMU_PROTO_CHECK_EN, the port and all its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-031 The package ad7606_pkg SHALL hold the state encoding (IDLE=0, RST=1, CONV=2, READY=3), the channel count 8 and the default conversion time.
REQ-032 One sub-module, ad7606_edge_det (registered rise/fall detector), SHALL be instantiated for convst, rd_i and reset_i.

Verification (CONV_CYCLES = 8)
REQ-033 Reset sequence: reset_i = 1 for 2 cycles, then cst -> busy_o = 1 from cycle +1 to +8 inclusive, and 0 at +9.
REQ-034 Full readout: ch_data_i = {16'h0008, ..., 16'h0001}, cst, wait for busy_o = 0, then 8 rd_i low/high pairs with cs_i = 0 -> reads are 1..8; frstdata_o = 1 only on word 1.
REQ-035 Wrap: a 9th read -> 16'h0001 with frstdata_o = 1; with the macro defined, proto_err_o pulses once.
REQ-036 cst at busy cycle 4 -> busy_o still falls at cycle 9; the data is from the first latch.
REQ-037 reset_i = 1 at busy cycle 3 -> busy_o = 0 the next cycle; a later read returns 0 (state not READY).
REQ-038 rst_n_i asserted mid-readout (ptr = 5) -> all outputs 0 asynchronously; after release, cst plus a read returns the new V1.
